// File: rtl/mem_io_arbiter.sv
// Shared data-memory / IO port arbiter between the CPU load/store unit and the UART loader.
// Round-robin between requesters, one transaction in flight, memory reads wait MEM_LAT cycles.
module mem_io_arbiter #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        ldr_req,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        io_rd,
  output logic        io_wr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata
);

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic        grant_ldr;
  logic        last_grant;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [1:0]  wait_cnt;
  logic        io_sel;
  logic        pick_ldr;
  logic        any_req;

  assign io_sel    = (addr_q >= IO_BASE);
  assign any_req   = cpu_req | ldr_req;
  // last_grant = 1 means the loader was served last, so the CPU wins a tie
  assign pick_ldr  = ldr_req & (~cpu_req | ~last_grant);
  assign cpu_stall = cpu_req & ~cpu_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    io_wdata   = 16'h0;
    cpu_done   = 1'b0;
    ldr_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = ISSUE;
      end
      ISSUE: begin
        if (!io_sel) begin
          mem_en    = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end else if (!grant_ldr) begin
          // loader writes into IO space are swallowed but still acknowledged
          io_wr    = we_q;
          io_rd    = ~we_q;
          io_wdata = we_q ? wdata_q[15:0] : 16'h0;
        end
        state_next = (!io_sel && !we_q) ? WAIT : RESP;
      end
      WAIT: begin
        if (wait_cnt == LAT_LAST) state_next = RESP;
      end
      RESP: begin
        cpu_done   = ~grant_ldr;
        ldr_ack    = grant_ldr;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latching, arbitration history, WAIT counter and load-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_ldr  <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      wait_cnt   <= 2'd0;
      cpu_rdata  <= 32'h0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_ldr  <= pick_ldr;
        last_grant <= pick_ldr;
        addr_q     <= pick_ldr ? ldr_addr : cpu_addr;
        wdata_q    <= pick_ldr ? ldr_wdata : cpu_wdata;
        we_q       <= pick_ldr | cpu_we;
      end
      if (state == ISSUE && io_sel && !we_q) begin
        cpu_rdata <= {16'h0000, io_rdata};
      end
      if (state == WAIT) begin
        if (wait_cnt == LAT_LAST) begin
          wait_cnt  <= 2'd0;
          cpu_rdata <= mem_rdata;
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
      end else begin
        wait_cnt <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Bench for mem_io_arbiter: directed and random CPU/loader transactions against a
// transaction-level reference, plus a MEM_LAT=3 instance for latency and mid-flight reset.
module tb_mem_io_arbiter;

  localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
  localparam int          MEM_LAT1 = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_req, cpu_we, ldr_req;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_stall, ldr_ack, mem_en, mem_we, io_rd, io_wr;
  logic [15:0] io_wdata, io_rdata;

  logic        rst_n3, cpu_req3;
  logic [31:0] cpu_addr3;
  logic [31:0] cpu_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        cpu_done3, cpu_stall3, ldr_ack3, mem_en3, mem_we3, io_rd3, io_wr3;
  logic [15:0] io_wdata3;

  int          checks, errors;
  logic [31:0] ref_mem [0:16];
  logic [31:0] ref_rdata;
  bit          ref_last_ldr;

  logic [83:0] bus1, bus3;
  assign bus1 = {mem_en, mem_we, mem_addr, mem_wdata, io_rd, io_wr, io_wdata};
  assign bus3 = {mem_en3, mem_we3, mem_addr3, mem_wdata3, io_rd3, io_wr3, io_wdata3};

  mem_io_arbiter #(.IO_BASE(IO_BASE), .MEM_LAT(MEM_LAT1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  mem_io_arbiter #(.IO_BASE(IO_BASE), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n3),
    .cpu_req(cpu_req3), .cpu_we(1'b0), .cpu_addr(cpu_addr3), .cpu_wdata(32'h0),
    .cpu_rdata(cpu_rdata3), .cpu_done(cpu_done3), .cpu_stall(cpu_stall3),
    .ldr_req(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0), .ldr_ack(ldr_ack3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3),
    .io_rd(io_rd3), .io_wr(io_wr3), .io_wdata(io_wdata3), .io_rdata(16'h0)
  );

  function automatic int word_idx(input logic [31:0] a);
    return (a == 32'hFFFF_FBFC) ? 16 : int'(a[5:2]);
  endfunction

  // Data memory behind dut: read data valid only in the cycle after the enable
  logic [31:0] slave_mem [0:16];
  logic        rd_v;
  logic [31:0] rd_d;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 17; i++) slave_mem[i] <= 32'h0;
      rd_v <= 1'b0;
      rd_d <= 32'h0;
    end else begin
      rd_v <= mem_en && !mem_we;
      rd_d <= slave_mem[word_idx(mem_addr)];
      if (mem_en && mem_we) slave_mem[word_idx(mem_addr)] <= mem_wdata;
    end
  end
  assign mem_rdata = rd_v ? rd_d : 32'hBADB_AD00;

  // Three-cycle memory behind dut3 returning a fixed word
  logic [2:0] v3 = 3'b000;
  always @(posedge clk) v3 <= {v3[1:0], mem_en3 && !mem_we3};
  assign mem_rdata3 = v3[2] ? 32'h0BAD_F00D : 32'hBADB_AD00;

  task automatic checkOutput(input string tag, input logic [83:0] got, input logic [83:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int txn_lat(input bit we, input logic [31:0] a);
    return (we || a >= IO_BASE) ? 2 : 2 + MEM_LAT1;
  endfunction

  function automatic logic [83:0] issue_vec(input bit is_ldr, input bit we,
                                            input logic [31:0] a, input logic [31:0] wd);
    if (a < IO_BASE) return {1'b1, we, a, wd, 18'h0};
    if (is_ldr) return 84'h0;
    if (we) return {66'h0, 2'b01, wd[15:0]};
    return {66'h0, 2'b10, 16'h0};
  endfunction

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 32'($urandom_range(0, 15) * 4);
    if (r == 6) return 32'hFFFF_FBFC;
    if (r == 7) return IO_BASE;
    return IO_BASE + 32'($urandom_range(1, 255) * 4);
  endfunction

  // One CPU and/or loader request starting from IDLE; the reference decides order,
  // per-cycle strobes, completion cycles and the load data.
  task automatic applyStimulus(input bit c_on, input bit c_we, input logic [31:0] c_addr,
                               input logic [31:0] c_wd, input bit l_on,
                               input logic [31:0] l_addr, input logic [31:0] l_wd,
                               input logic [15:0] io_val);
    bit          first_ldr;
    int          c_start, c_done, l_start, l_done, last;
    logic [83:0] c_bus, l_bus, exp_bus;
    logic [31:0] c_rd;
    bit          c_io_rd;
    if (c_on && l_on) first_ldr = !ref_last_ldr;
    else first_ldr = l_on;
    if (first_ldr) begin
      l_start = 0;
      l_done  = 2;
      c_start = l_done + 1;
      c_done  = c_start + txn_lat(c_we, c_addr);
    end else begin
      c_start = 0;
      c_done  = txn_lat(c_we, c_addr);
      l_start = c_done + 1;
      l_done  = l_start + 2;
    end
    if (!c_on) begin c_start = -10; c_done = -10; end
    if (!l_on) begin l_start = -10; l_done = -10; end
    if (l_on && first_ldr && l_addr < IO_BASE) ref_mem[word_idx(l_addr)] = l_wd;
    c_rd    = 32'h0;
    c_io_rd = c_on && !c_we && c_addr >= IO_BASE;
    if (c_on && !c_we) c_rd = (c_addr >= IO_BASE) ? {16'h0, io_val} : ref_mem[word_idx(c_addr)];
    if (c_on && c_we && c_addr < IO_BASE) ref_mem[word_idx(c_addr)] = c_wd;
    if (l_on && !first_ldr && l_addr < IO_BASE) ref_mem[word_idx(l_addr)] = l_wd;
    ref_last_ldr = (c_on && l_on) ? !first_ldr : first_ldr;
    c_bus = issue_vec(1'b0, c_we, c_addr, c_wd);
    l_bus = issue_vec(1'b1, 1'b1, l_addr, l_wd);
    last  = (c_done > l_done) ? c_done : l_done;

    @(negedge clk);
    cpu_req = c_on; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    ldr_req = l_on; ldr_addr = l_addr; ldr_wdata = l_wd;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      io_rdata = (c_io_rd && k == c_start + 1) ? io_val : ~io_val;
      #1;
      exp_bus = (k == c_start + 1) ? c_bus : (k == l_start + 1) ? l_bus : 84'h0;
      if (c_on && !c_we && k == c_done) ref_rdata = c_rd;
      checkOutput("bus", bus1, exp_bus);
      checkOutput("cpu_done", 84'(cpu_done), 84'(k == c_done));
      checkOutput("ldr_ack", 84'(ldr_ack), 84'(k == l_done));
      checkOutput("cpu_stall", 84'(cpu_stall), 84'(c_on && k < c_done));
      checkOutput("cpu_rdata", 84'(cpu_rdata), 84'(ref_rdata));
      if (k == c_done) begin
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (k == l_done) begin
        ldr_req = 1'b0; ldr_addr = $urandom; ldr_wdata = $urandom;
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; rst_n3 = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ldr_req = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0; io_rdata = 16'h0;
    cpu_req3 = 1'b0; cpu_addr3 = 32'h0;
    for (int i = 0; i < 17; i++) ref_mem[i] = 32'h0;
    ref_rdata = 32'h0;
    ref_last_ldr = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_bus", bus1, 84'h0);
    checkOutput("reset_done_ack_stall", 84'({cpu_done, ldr_ack, cpu_stall}), 84'h0);
    checkOutput("reset_rdata", 84'(cpu_rdata), 84'h0);
    checkOutput("reset3_all", {bus3[51:0], cpu_rdata3}, 84'h0);
    checkOutput("reset3_flags", 84'({cpu_done3, ldr_ack3, cpu_stall3}), 84'h0);
    @(negedge clk);
    rst_n = 1'b1; rst_n3 = 1'b1;

    // Tie right after reset: CPU first, then loader
    applyStimulus(1, 0, 32'h0000_0000, 32'h1111_2222, 1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0);
    applyStimulus(1, 0, 32'h0000_0010, 32'h0, 0, 32'h0, 32'h0, 16'h0);
    checkOutput("mem_load_data", 84'(cpu_rdata), 84'(32'hDEAD_BEEF));
    applyStimulus(1, 1, 32'hFFFF_FC60, 32'h1234_ABCD, 0, 32'h0, 32'h0, 16'h0);
    applyStimulus(1, 0, 32'hFFFF_FC70, 32'h0, 0, 32'h0, 32'h0, 16'h00F3);
    checkOutput("io_load_data", 84'(cpu_rdata), 84'(32'h0000_00F3));
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FC00, 32'h5555_AAAA, 16'h0);
    applyStimulus(1, 1, 32'hFFFF_FC00, 32'h0000_7E57, 0, 32'h0, 32'h0, 16'h0);
    applyStimulus(1, 1, 32'hFFFF_FBFC, 32'hA5A5_5A5A, 0, 32'h0, 32'h0, 16'h0);
    applyStimulus(1, 0, 32'hFFFF_FBFC, 32'h0, 1, 32'h0000_0020, 32'h0F0F_0F0F, 16'h0);
    applyStimulus(1, 1, 32'h0000_0024, 32'h7777_8888, 1, 32'h0000_0028, 32'h9999_0000, 16'h0);

    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = $urandom_range(0, 2);
      applyStimulus(sel != 1, 1'($urandom), pick_addr(), $urandom,
                    sel != 0, pick_addr(), $urandom, 16'($urandom));
    end

    // MEM_LAT=3 load: enable at N+1, done with data at N+5
    @(negedge clk);
    cpu_req3 = 1'b1; cpu_addr3 = 32'h0000_0030;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput("lat3_done", 84'(cpu_done3), 84'(k == 5));
      checkOutput("lat3_mem_en", 84'(mem_en3), 84'(k == 1));
      if (k == 5) begin
        checkOutput("lat3_rdata", 84'(cpu_rdata3), 84'(32'h0BAD_F00D));
        cpu_req3 = 1'b0;
      end
    end

    // Second load aborted by reset in N+3
    @(negedge clk);
    cpu_req3 = 1'b1; cpu_addr3 = 32'h0000_0034;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput("abort_pre_done", 84'(cpu_done3), 84'h0);
    end
    @(negedge clk);
    rst_n3 = 1'b0;
    #1;
    checkOutput("abort_bus", bus3, 84'h0);
    checkOutput("abort_flags", 84'({cpu_done3, ldr_ack3}), 84'h0);
    checkOutput("abort_rdata", 84'(cpu_rdata3), 84'h0);
    cpu_req3 = 1'b0;
    @(negedge clk);
    rst_n3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      checkOutput("abort_post_done", 84'({cpu_done3, cpu_stall3}), 84'h0);
      checkOutput("abort_post_bus", bus3, 84'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
